// File: rtl/game_pkg.sv
// Shared definitions for the game round sequencer and the screen renderer.
// State encoding is one-hot; vga_bitchange decodes its enemy enables from
// these same constants, so the values must not change.
package game_pkg;

    localparam int LIVES_W = 2;
    localparam int TIMER_W = 32;

    typedef enum logic [5:0] {
        ST_I      = 6'b000001,
        ST_FIRST  = 6'b000010,
        ST_SECOND = 6'b000100,
        ST_THIRD  = 6'b001000,
        ST_FINAL  = 6'b010000,
        ST_WIN    = 6'b100000
    } state_t;

    // Successor of a round state after that round is won.
    function automatic state_t next_round(input state_t s);
        case (s)
            ST_FIRST:  return ST_SECOND;
            ST_SECOND: return ST_THIRD;
            ST_THIRD:  return ST_FINAL;
            ST_FINAL:  return ST_WIN;
            default:   return ST_I;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector. A held button yields a single one-cycle edge.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_edge
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next values: shift the button through the synchronizer and history flop.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign btn_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/game_round_sm.sv
// Round sequencer for the VGA shooter: I -> First -> Second -> Third ->
// Final -> Win, with per-round timeout, collision loss and a round_start
// pulse used downstream to re-seed player and enemy positions.
// Optional feature macro: GAME_LIVES_EN (lives counter; without it any
// loss returns to I and lives_left is tied to 0).
module game_round_sm
    import game_pkg::*;
#(
    parameter logic [31:0]        ROUND_TIMEOUT = 32'd3_000_000_000,
    parameter logic [LIVES_W-1:0] LIVES         = 2'd3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               BtnC,
    input  logic               wonFirstRound,
    input  logic               wonSecondRound,
    input  logic               wonThirdRound,
    input  logic               wonFourthRound,
    input  logic               collidedWithEnemy,
    output logic               q_I,
    output logic               q_First,
    output logic               q_Second,
    output logic               q_Third,
    output logic               q_Final,
    output logic               q_Win,
    output logic               round_start,
    output logic [LIVES_W-1:0] lives_left
);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 round_start_q, round_start_d;
    logic                 btn_edge;
    logic                 cur_win;
    logic                 timeout;
    logic                 loss;

`ifdef GAME_LIVES_EN
    logic [LIVES_W-1:0]   lives_q, lives_d;
`else
    logic                 unused_lives;
    assign unused_lives = ^LIVES;
`endif

    btn_sync_edge u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (BtnC),
        .btn_edge (btn_edge)
    );

    // Select the win flag belonging to the current round; other flags are ignored.
    always_comb begin
        cur_win = 1'b0;
        case (state_q)
            ST_FIRST:  cur_win = wonFirstRound;
            ST_SECOND: cur_win = wonSecondRound;
            ST_THIRD:  cur_win = wonThirdRound;
            ST_FINAL:  cur_win = wonFourthRound;
            default:   cur_win = 1'b0;
        endcase
    end

    // Next-state, timer, lives and round_start logic; a loss beats a win.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        round_start_d = 1'b0;
`ifdef GAME_LIVES_EN
        lives_d       = lives_q;
`endif
        timeout = (timer_q == ROUND_TIMEOUT - 32'd1);
        loss    = collidedWithEnemy | timeout;

        case (state_q)
            ST_I: begin
                timer_d = '0;
                if (btn_edge) begin
                    state_d       = ST_FIRST;
                    round_start_d = 1'b1;
`ifdef GAME_LIVES_EN
                    lives_d       = LIVES;
`endif
                end
            end
            ST_FIRST, ST_SECOND, ST_THIRD, ST_FINAL: begin
                // Saturating count so the timer can never wrap.
                timer_d = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
                if (loss) begin
                    timer_d = '0;
`ifdef GAME_LIVES_EN
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d       = lives_q - LIVES_W'(1);
                        round_start_d = 1'b1;
                    end else begin
                        lives_d = '0;
                        state_d = ST_I;
                    end
`else
                    state_d = ST_I;
`endif
                end else if (cur_win) begin
                    state_d       = next_round(state_q);
                    timer_d       = '0;
                    round_start_d = (state_q != ST_FINAL);
                end
            end
            ST_WIN: begin
                timer_d = '0;
                if (btn_edge) begin
                    state_d = ST_I;
                end
            end
            default: begin
                // Non-one-hot encoding: recover to the idle state.
                state_d = ST_I;
                timer_d = '0;
            end
        endcase
    end

    // State, timer and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_I;
            timer_q       <= '0;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            round_start_q <= round_start_d;
        end
    end

`ifdef GAME_LIVES_EN
    // Lives counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q <= LIVES;
        end else begin
            lives_q <= lives_d;
        end
    end

    assign lives_left = lives_q;
`else
    assign lives_left = '0;
`endif

    assign {q_Win, q_Final, q_Third, q_Second, q_First, q_I} = state_q;
    assign round_start = round_start_q;

endmodule
